// File: rtl/stream_mux_n.sv
// N-to-1 stream multiplexer with a registered output stage.
// The source channel is picked by an external select or by round-robin arbitration.
module stream_mux_lane #(
  parameter int MODE = 1,
  parameter int SELW = 2,
  parameter int IDX  = 0
) (
  input  logic            valid,
  input  logic [SELW-1:0] sel,
  input  logic            gnt,
  input  logic            load,
  output logic            req,
  output logic            ready
);
  // With external select a lane only requests while it is the addressed channel.
  assign req   = (MODE == 0) ? (valid && (sel == SELW'(IDX))) : valid;
  assign ready = load && gnt;
endmodule

module stream_mux_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = 1,
  localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SELW-1:0]           out_chan,
  input  logic                      out_ready
);
  logic                load;
  logic [CHANNELS-1:0] req, gnt;
  logic                gnt_vld;
  logic [SELW-1:0]     gnt_idx, last_grant;
  logic [WIDTH-1:0]    gnt_data;
  int                  idx;

  assign load = !out_valid || out_ready;

  genvar k;
  generate
    for (k = 0; k < CHANNELS; k++) begin : g_lane
      assign gnt[k] = gnt_vld && (gnt_idx == SELW'(k));
      stream_mux_lane #(.MODE(MODE), .SELW(SELW), .IDX(k)) u_lane (
        .valid (in_valid[k]),
        .sel   (sel),
        .gnt   (gnt[k]),
        .load  (load),
        .req   (req[k]),
        .ready (in_ready[k])
      );
    end
  endgenerate

  // Round-robin: walk offsets high-to-low so the nearest requester after
  // last_grant is the one left standing.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (MODE == 0) begin
      for (int i = 0; i < CHANNELS; i++)
        if (req[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(i);
        end
    end else begin
      for (int i = CHANNELS; i >= 1; i--) begin
        idx = int'(last_grant) + i;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (req[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (gnt_idx == SELW'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      last_grant <= SELW'(CHANNELS - 1);
    end else if (load) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data <= gnt_data;
        out_chan <= gnt_idx;
        if (MODE == 1) last_grant <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench: round-robin 4-channel instance and external-select 3-channel instance.
module tb_stream_mux_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // round-robin, 4 channels
  logic [31:0] a_data;
  logic [3:0]  a_valid, a_ready;
  logic [1:0]  a_sel, a_chan;
  logic [7:0]  a_odata;
  logic        a_ovalid, a_oready;

  // external select, 3 channels
  logic [23:0] b_data;
  logic [2:0]  b_valid, b_ready;
  logic [1:0]  b_sel, b_chan;
  logic [7:0]  b_odata;
  logic        b_ovalid, b_oready;

  stream_mux_n #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .sel(a_sel), .out_data(a_odata), .out_valid(a_ovalid), .out_chan(a_chan),
    .out_ready(a_oready));

  stream_mux_n #(.WIDTH(8), .CHANNELS(3), .MODE(0)) u_ext (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .sel(b_sel), .out_data(b_odata), .out_valid(b_ovalid), .out_chan(b_chan),
    .out_ready(b_oready));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_ch [4];
    exp_ch = '{2'd1, 2'd3, 2'd1, 2'd3};
    a_data = {8'h13, 8'h12, 8'h11, 8'h10};
    a_valid = '0; a_sel = '0; a_oready = 1'b1;
    b_data = '0; b_valid = '0; b_sel = '0; b_oready = 1'b1;

    // reset state
    #2;
    chk("rst_valid", a_ovalid, 0);
    chk("rst_data",  a_odata, 0);
    chk("rst_chan",  a_chan, 0);
    step(); step();
    rst = 1'b0;

    // all channels valid: 0,1,2,3 in order
    a_valid = 4'hF;
    #1;
    chk("rr_first_ready", a_ready, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr_chan%0d", i), a_chan, i);
      chk($sformatf("rr_data%0d", i), a_odata, 8'h10 + i);
      chk($sformatf("rr_valid%0d", i), a_ovalid, 1);
    end

    // back-pressure holding 0x13
    a_oready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ready%0d", i), a_ready, 4'b0000);
      step();
      chk($sformatf("bp_data%0d", i), a_odata, 8'h13);
      chk($sformatf("bp_valid%0d", i), a_ovalid, 1);
    end
    a_oready = 1'b1;
    #1;
    chk("bp_release_ready", a_ready, 4'b0001);
    step();
    chk("bp_release_data", a_odata, 8'h10);
    chk("bp_release_chan", a_chan, 0);

    // only ch1 and ch3 valid: alternate 1,3,1,3
    a_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("alt_ready%0d", i), a_ready, 4'b0001 << exp_ch[i]);
      step();
      chk($sformatf("alt_chan%0d", i), a_chan, exp_ch[i]);
    end

    // drain to idle
    a_valid = '0;
    step();
    chk("drain_valid", a_ovalid, 0);

    // async reset while holding a word
    a_valid = 4'b0001;
    step();
    chk("pre_rst_valid", a_ovalid, 1);
    a_valid = '0;
    a_oready = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", a_ovalid, 0);
    chk("async_rst_data",  a_odata, 0);
    step();
    rst = 1'b0;
    a_oready = 1'b1;
    #1;
    chk("rst_release_valid", a_ovalid, 0);
    a_valid = 4'hF;
    #1;
    chk("rst_prio_ready", a_ready, 4'b0001);
    step();
    chk("rst_prio_chan", a_chan, 0);
    a_valid = '0;

    // external select: load one word from ch0
    b_sel = 2'd0;
    b_valid = 3'b001;
    b_data = {8'hAB, 8'h22, 8'h55};
    step();
    chk("ext_ch0_data", b_odata, 8'h55);
    chk("ext_ch0_valid", b_ovalid, 1);
    // sel=2 without valid: no grant, output drains
    b_sel = 2'd2;
    b_valid = 3'b011;
    #1;
    chk("ext_nogrant_ready", b_ready, 3'b000);
    step();
    chk("ext_nogrant_valid", b_ovalid, 0);
    // sel=2 valid
    b_valid = 3'b111;
    #1;
    chk("ext_sel2_ready", b_ready, 3'b100);
    step();
    chk("ext_sel2_data", b_odata, 8'hAB);
    chk("ext_sel2_chan", b_chan, 2);
    chk("ext_sel2_valid", b_ovalid, 1);
    // sel out of range
    b_sel = 2'd3;
    #1;
    chk("ext_oor_ready", b_ready, 3'b000);
    step();
    chk("ext_oor_valid0", b_ovalid, 0);
    step();
    chk("ext_oor_valid1", b_ovalid, 0);
    chk("ext_oor_ready1", b_ready, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
